// File: rtl/jt6295_ch_seq_pkg.sv
// Shared definitions for the jt6295 channel sequencer.
//   NCH      : number of ADPCM channels served round-robin
//   SLOT_W   : width of the slot (channel) index
//   AW_DEF   : default ROM byte address width
//   ptr_w()  : nibble pointer width, one bit wider than the byte address
//   state_e  : sequencer FSM encoding
package jt6295_ch_seq_pkg;

   localparam int unsigned NCH    = 4;
   localparam int unsigned SLOT_W = 2;
   localparam int unsigned AW_DEF = 18;

   // Nibble pointer is {byte address, nibble select}.
   function automatic int unsigned ptr_w(input int unsigned aw);
      return aw + 1;
   endfunction

   typedef enum logic [1:0] {StIdle, StChk, StFetch, StAdv} state_e;

endpackage

// File: rtl/jt6295_ch_edge.sv
// Per-channel start/stop edge capture for the jt6295 channel sequencer.
//   clk_i, rst_ni         : clock, asynchronous active-low reset
//   start_addr_i, ...     : phrase parameters presented with a start request
//   start_i, stop_i       : level masks from the controller
//   active_i              : channel currently playing
//   clr_i                 : sequencer consumed this channel's pending events
//   pend_start_o/stop_o   : pending events per channel
//   sh_start/stop/att_o   : phrase parameters latched on the start rise
module jt6295_ch_edge
   import jt6295_ch_seq_pkg::*;
#(
   parameter int unsigned AW = AW_DEF
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [AW-1:0]           start_addr_i,
   input  logic [AW-1:0]           stop_addr_i,
   input  logic [3:0]              att_i,
   input  logic [NCH-1:0]          start_i,
   input  logic [NCH-1:0]          stop_i,
   input  logic [NCH-1:0]          active_i,
   input  logic [NCH-1:0]          clr_i,
   output logic [NCH-1:0]          pend_start_o,
   output logic [NCH-1:0]          pend_stop_o,
   output logic [NCH-1:0][AW-1:0]  sh_start_o,
   output logic [NCH-1:0][AW-1:0]  sh_stop_o,
   output logic [NCH-1:0][3:0]     sh_att_o
);

   logic [NCH-1:0]         start_q, stop_q;
   logic [NCH-1:0]         pend_start_q, pend_start_d;
   logic [NCH-1:0]         pend_stop_q, pend_stop_d;
   logic [NCH-1:0][AW-1:0] sh_start_q, sh_start_d, sh_stop_q, sh_stop_d;
   logic [NCH-1:0][3:0]    sh_att_q, sh_att_d;
   logic [NCH-1:0]         start_rise, stop_rise;

   assign start_rise = start_i & ~start_q;
   assign stop_rise  = stop_i & ~stop_q;

   always_comb begin
      pend_start_d = pend_start_q;
      sh_start_d   = sh_start_q;
      sh_stop_d    = sh_stop_q;
      sh_att_d     = sh_att_q;
      // A fresh stop rise survives a same-cycle clear.
      pend_stop_d  = (pend_stop_q & ~clr_i) | stop_rise;
      for (int i = 0; i < NCH; i++) begin
         if (stop_rise[i]) begin
            // Stop beats a simultaneous start.
            pend_start_d[i] = 1'b0;
         end else if (start_rise[i] && !active_i[i]) begin
            pend_start_d[i] = 1'b1;
            sh_start_d[i]   = start_addr_i;
            sh_stop_d[i]    = stop_addr_i;
            sh_att_d[i]     = att_i;
         end else if (clr_i[i]) begin
            pend_start_d[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         start_q      <= '0;
         stop_q       <= '0;
         pend_start_q <= '0;
         pend_stop_q  <= '0;
         sh_start_q   <= '0;
         sh_stop_q    <= '0;
         sh_att_q     <= '0;
      end else begin
         start_q      <= start_i;
         stop_q       <= stop_i;
         pend_start_q <= pend_start_d;
         pend_stop_q  <= pend_stop_d;
         sh_start_q   <= sh_start_d;
         sh_stop_q    <= sh_stop_d;
         sh_att_q     <= sh_att_d;
      end
   end

   assign pend_start_o = pend_start_q;
   assign pend_stop_o  = pend_stop_q;
   assign sh_start_o   = sh_start_q;
   assign sh_stop_o    = sh_stop_q;
   assign sh_att_o     = sh_att_q;

endmodule

// File: rtl/jt6295_ch_seq.sv
// Four-channel ADPCM nibble sequencer. Each cen4 slot serves one channel
// (round-robin 0..3), fetching ROM bytes as needed and emitting one 4-bit code.
//   clk, rst_n                       : clock, asynchronous active-low reset
//   cen4                             : slot strobe
//   start_addr/stop_addr/att         : phrase parameters from the controller
//   start, stop                      : per-channel request level masks
//   busy                             : channel active or start pending
//   rom_addr/rom_cs/rom_data/rom_ok  : ROM byte interface
//   smp_*                            : registered sample towards the decoder
//   overrun                          : sticky, cen4 arrived mid-slot
module jt6295_ch_seq
   import jt6295_ch_seq_pkg::*;
#(
   parameter int unsigned AW = AW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cen4,
   input  logic [AW-1:0] start_addr,
   input  logic [AW-1:0] stop_addr,
   input  logic [3:0]    att,
   input  logic [3:0]    start,
   input  logic [3:0]    stop,
   output logic [3:0]    busy,
   output logic [AW-1:0] rom_addr,
   output logic          rom_cs,
   input  logic [7:0]    rom_data,
   input  logic          rom_ok,
   output logic          smp_valid,
   output logic [1:0]    smp_ch,
   output logic [3:0]    smp_nib,
   output logic [3:0]    smp_att,
   output logic          smp_act,
   output logic          smp_first,
   output logic          overrun
);

   localparam int unsigned PW = ptr_w(AW);

   state_e                  state_q, state_d;
   logic [SLOT_W-1:0]       slot_q, slot_d;
   logic [NCH-1:0][PW-1:0]  ptr_q, ptr_d;
   logic [NCH-1:0][AW-1:0]  end_q, end_d;
   logic [NCH-1:0][3:0]     att_q, att_d, low_q, low_d;
   logic [NCH-1:0]          active_q, active_d, first_q, first_d;
   logic                    smp_valid_q, smp_valid_d, smp_act_q, smp_act_d;
   logic                    smp_first_q, smp_first_d, overrun_q, overrun_d;
   logic [1:0]              smp_ch_q, smp_ch_d;
   logic [3:0]              smp_nib_q, smp_nib_d, smp_att_q, smp_att_d;

   logic [NCH-1:0]          clr, pend_start, pend_stop;
   logic [NCH-1:0][AW-1:0]  sh_start, sh_stop;
   logic [NCH-1:0][3:0]     sh_att;

   jt6295_ch_edge #(
      .AW (AW)
   ) u_edge (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .start_addr_i (start_addr),
      .stop_addr_i  (stop_addr),
      .att_i        (att),
      .start_i      (start),
      .stop_i       (stop),
      .active_i     (active_q),
      .clr_i        (clr),
      .pend_start_o (pend_start),
      .pend_stop_o  (pend_stop),
      .sh_start_o   (sh_start),
      .sh_stop_o    (sh_stop),
      .sh_att_o     (sh_att)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // Next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (cen4) state_d = StChk;
         StChk:   state_d = (active_q[slot_q] && !ptr_q[slot_q][0]) ? StFetch : StAdv;
         StFetch: if (rom_ok) state_d = StAdv;
         StAdv:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Outputs driven straight from state so rom_cs drops with reset
   always_comb begin
      rom_cs   = (state_q == StFetch);
      rom_addr = rom_cs ? ptr_q[slot_q][PW-1:1] : '0;
   end

   // Channel datapath and sample emission
   always_comb begin
      slot_d      = slot_q;
      ptr_d       = ptr_q;
      end_d       = end_q;
      att_d       = att_q;
      low_d       = low_q;
      active_d    = active_q;
      first_d     = first_q;
      clr         = '0;
      smp_valid_d = 1'b0;
      smp_ch_d    = smp_ch_q;
      smp_nib_d   = smp_nib_q;
      smp_att_d   = smp_att_q;
      smp_act_d   = smp_act_q;
      smp_first_d = smp_first_q;
      overrun_d   = overrun_q | (cen4 && (state_q != StIdle));

      unique case (state_q)
         StIdle: begin
            if (cen4) begin
               clr[slot_q] = 1'b1;
               if (pend_stop[slot_q]) active_d[slot_q] = 1'b0;
               if (pend_start[slot_q]) begin
                  ptr_d[slot_q]    = {sh_start[slot_q], 1'b0};
                  end_d[slot_q]    = sh_stop[slot_q];
                  att_d[slot_q]    = sh_att[slot_q];
                  active_d[slot_q] = 1'b1;
                  first_d[slot_q]  = 1'b1;
               end
            end
         end
         StChk: begin
            if (!active_q[slot_q] || ptr_q[slot_q][0]) begin
               smp_valid_d = 1'b1;
               smp_ch_d    = slot_q;
               smp_att_d   = att_q[slot_q];
               smp_act_d   = active_q[slot_q];
               smp_first_d = active_q[slot_q] & first_q[slot_q];
               smp_nib_d   = active_q[slot_q] ? low_q[slot_q] : 4'h0;
            end
         end
         StFetch: begin
            if (rom_ok) begin
               low_d[slot_q] = rom_data[3:0];
               smp_valid_d   = 1'b1;
               smp_ch_d      = slot_q;
               smp_att_d     = att_q[slot_q];
               smp_act_d     = 1'b1;
               smp_first_d   = first_q[slot_q];
               smp_nib_d     = rom_data[7:4];
            end
         end
         StAdv: begin
            if (active_q[slot_q]) begin
               if (ptr_q[slot_q][0] && (ptr_q[slot_q][PW-1:1] == end_q[slot_q])) begin
                  active_d[slot_q] = 1'b0;
               end else begin
                  // Toggles the nibble and carries into the byte address, wrapping at 2^AW.
                  ptr_d[slot_q] = ptr_q[slot_q] + 1'b1;
               end
            end
            first_d[slot_q] = 1'b0;
            slot_d          = slot_q + 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q      <= '0;
         ptr_q       <= '0;
         end_q       <= '0;
         att_q       <= '0;
         low_q       <= '0;
         active_q    <= '0;
         first_q     <= '0;
         smp_valid_q <= 1'b0;
         smp_ch_q    <= '0;
         smp_nib_q   <= '0;
         smp_att_q   <= '0;
         smp_act_q   <= 1'b0;
         smp_first_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         slot_q      <= slot_d;
         ptr_q       <= ptr_d;
         end_q       <= end_d;
         att_q       <= att_d;
         low_q       <= low_d;
         active_q    <= active_d;
         first_q     <= first_d;
         smp_valid_q <= smp_valid_d;
         smp_ch_q    <= smp_ch_d;
         smp_nib_q   <= smp_nib_d;
         smp_att_q   <= smp_att_d;
         smp_act_q   <= smp_act_d;
         smp_first_q <= smp_first_d;
         overrun_q   <= overrun_d;
      end
   end

   assign busy      = active_q | pend_start;
   assign smp_valid = smp_valid_q;
   assign smp_ch    = smp_ch_q;
   assign smp_nib   = smp_nib_q;
   assign smp_att   = smp_att_q;
   assign smp_act   = smp_act_q;
   assign smp_first = smp_first_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_jt6295_ch_seq.sv
// Scoreboard bench for jt6295_ch_seq: expected samples are queued per slot
// before cen4 pulses are issued and popped as smp_valid pulses arrive.
module tb_jt6295_ch_seq;

   typedef struct packed {
      logic [1:0] ch;
      logic       act;
      logic [3:0] nib;
      logic       first;
      logic [3:0] att;
   } smp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cen4;
   logic [17:0] start_addr, stop_addr;
   logic [3:0]  att, start, stop;
   logic [3:0]  busy;
   logic [17:0] rom_addr;
   logic        rom_cs;
   logic [7:0]  rom_data;
   logic        rom_ok;
   logic        smp_valid;
   logic [1:0]  smp_ch;
   logic [3:0]  smp_nib, smp_att;
   logic        smp_act, smp_first, overrun;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cen_left = 0;
   int          cen_period = 8;
   logic        rom_stall = 1'b0;
   smp_t        exp_q[$];
   logic [17:0] rd_log[$];

   jt6295_ch_seq #(
      .AW (18)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cen4       (cen4),
      .start_addr (start_addr),
      .stop_addr  (stop_addr),
      .att        (att),
      .start      (start),
      .stop       (stop),
      .busy       (busy),
      .rom_addr   (rom_addr),
      .rom_cs     (rom_cs),
      .rom_data   (rom_data),
      .rom_ok     (rom_ok),
      .smp_valid  (smp_valid),
      .smp_ch     (smp_ch),
      .smp_nib    (smp_nib),
      .smp_att    (smp_att),
      .smp_act    (smp_act),
      .smp_first  (smp_first),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] rom_byte(input logic [17:0] a);
      case (a)
         18'h00100: return 8'hA5;
         18'h00101: return 8'h3C;
         default:   return a[7:0] ^ 8'h5A;
      endcase
   endfunction

   // cen4 generator: cen_left pulses, one every cen_period clocks
   initial begin
      int cnt;
      cnt  = 0;
      cen4 = 1'b0;
      forever begin
         @(negedge clk);
         cen4 = 1'b0;
         if (cen_left > 0 && rst_n) begin
            cnt++;
            if (cnt >= cen_period) begin
               cen4 = 1'b1;
               cnt  = 0;
               cen_left--;
            end
         end
      end
   end

   // ROM: answers two clocks after rom_cs, unless stalled
   initial begin
      int wcnt;
      wcnt     = 0;
      rom_ok   = 1'b0;
      rom_data = 8'h00;
      forever begin
         @(negedge clk);
         if (rom_ok) begin
            rom_ok = 1'b0;
            wcnt   = 0;
         end else if (rom_cs && !rom_stall) begin
            if (wcnt >= 1) begin
               rom_ok   = 1'b1;
               rom_data = rom_byte(rom_addr);
               rd_log.push_back(rom_addr);
            end else begin
               wcnt++;
            end
         end else begin
            wcnt = 0;
         end
      end
   end

   // Scoreboard consumer
   initial begin
      smp_t e, got;
      forever begin
         @(negedge clk);
         if (smp_valid) begin
            n_checks++;
            got = '{ch: smp_ch, act: smp_act, nib: smp_nib, first: smp_first,
                    att: smp_act ? smp_att : 4'h0};
            if (exp_q.size() == 0) begin
               n_errors++;
               $display("FAIL unexpected_sample got=%h required=none", got);
            end else begin
               e = exp_q.pop_front();
               if (got !== e) begin
                  n_errors++;
                  $display("FAIL sample got ch=%0d act=%0b nib=%h first=%0b att=%h required ch=%0d act=%0b nib=%h first=%0b att=%h",
                           got.ch, got.act, got.nib, got.first, got.att,
                           e.ch, e.act, e.nib, e.first, e.att);
               end
            end
         end
      end
   end

   // One round of four slots starting at slot 0; channel ch carries the given sample.
   task automatic exp_round(input int ch, input logic act, input logic [3:0] nib,
                            input logic first, input logic [3:0] a);
      for (int s = 0; s < 4; s++) begin
         if (s == ch && act) exp_q.push_back('{ch: 2'(s), act: 1'b1, nib: nib, first: first, att: a});
         else                exp_q.push_back('{ch: 2'(s), act: 1'b0, nib: 4'h0, first: 1'b0, att: 4'h0});
      end
   endtask

   task automatic push_smp(input int ch, input logic act, input logic [3:0] nib,
                           input logic first, input logic [3:0] a);
      exp_q.push_back('{ch: 2'(ch), act: act, nib: nib, first: first, att: a});
   endtask

   task automatic wait_cen_left(input int target);
      int i;
      i = 0;
      while (cen_left > target && i < 3000) begin
         @(negedge clk);
         i++;
      end
      if (cen_left > target) begin
         n_checks++;
         n_errors++;
         $display("FAIL cen_timeout left=%0d required=%0d", cen_left, target);
      end
   endtask

   task automatic run_slots(input int n);
      cen_left = n;
      wait_cen_left(0);
      repeat (30) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL missing_samples got=%0d outstanding required=0", exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic pulse_start(input int ch, input logic [17:0] sa, input logic [17:0] ea,
                              input logic [3:0] a);
      start_addr = sa;
      stop_addr  = ea;
      att        = a;
      start[ch]  = 1'b1;
      repeat (2) @(negedge clk);
      start[ch]  = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = '0;
      stop  = '0;
      start_addr = '0;
      stop_addr  = '0;
      att   = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({rom_cs, smp_valid, overrun, busy} !== 7'b0) begin
         n_errors++;
         $display("FAIL reset_outputs got=%b required=0", {rom_cs, smp_valid, overrun, busy});
      end
      n_checks++;
      if (rom_addr !== 18'h0) begin
         n_errors++;
         $display("FAIL reset_rom_addr got=%h required=0", rom_addr);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_phrase();
      pulse_start(0, 18'h00100, 18'h00101, 4'h7);
      n_checks++;
      if (busy !== 4'b0001) begin
         n_errors++;
         $display("FAIL busy_after_start got=%b required=0001", busy);
      end
      exp_round(0, 1'b1, 4'hA, 1'b1, 4'h7);
      exp_round(0, 1'b1, 4'h5, 1'b0, 4'h7);
      exp_round(0, 1'b1, 4'h3, 1'b0, 4'h7);
      run_slots(12);
      n_checks++;
      if (busy !== 4'b0001) begin
         n_errors++;
         $display("FAIL busy_before_last got=%b required=0001", busy);
      end
      exp_round(0, 1'b1, 4'hC, 1'b0, 4'h7);
      exp_round(0, 1'b0, 4'h0, 1'b0, 4'h0);
      run_slots(8);
      n_checks++;
      if (busy !== 4'b0000) begin
         n_errors++;
         $display("FAIL busy_after_phrase got=%b required=0000", busy);
      end
      n_checks++;
      if (rd_log.size() != 2) begin
         n_errors++;
         $display("FAIL read_count got=%0d required=2", rd_log.size());
      end else if (rd_log[0] !== 18'h00100 || rd_log[1] !== 18'h00101) begin
         n_errors++;
         $display("FAIL read_addrs got=%h,%h required=00100,00101", rd_log[0], rd_log[1]);
      end
   endtask

   task automatic test_same_clk();
      int rd_n;
      rd_n     = rd_log.size();
      start[2] = 1'b1;
      stop[2]  = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (busy !== 4'b0000) begin
         n_errors++;
         $display("FAIL same_clk_busy got=%b required=0000", busy);
      end
      start[2] = 1'b0;
      stop[2]  = 1'b0;
      exp_round(0, 1'b0, 4'h0, 1'b0, 4'h0);
      run_slots(4);
      n_checks++;
      if (rd_log.size() != rd_n) begin
         n_errors++;
         $display("FAIL same_clk_reads got=%0d required=%0d", rd_log.size(), rd_n);
      end
   endtask

   task automatic test_stop_restart();
      pulse_start(1, 18'h00200, 18'h002FF, 4'h3);
      exp_round(1, 1'b1, 4'h5, 1'b1, 4'h3);
      exp_round(1, 1'b1, 4'hA, 1'b0, 4'h3);
      run_slots(8);
      n_checks++;
      if (busy !== 4'b0010) begin
         n_errors++;
         $display("FAIL busy_mid_phrase got=%b required=0010", busy);
      end
      stop[1] = 1'b1;
      repeat (2) @(negedge clk);
      exp_round(1, 1'b0, 4'h0, 1'b0, 4'h0);
      run_slots(4);
      n_checks++;
      if (busy !== 4'b0000) begin
         n_errors++;
         $display("FAIL busy_after_stop got=%b required=0000", busy);
      end
      stop[1] = 1'b0;
      pulse_start(1, 18'h00300, 18'h00300, 4'hB);
      exp_round(1, 1'b1, 4'h5, 1'b1, 4'hB);
      exp_round(1, 1'b1, 4'hA, 1'b0, 4'hB);
      exp_round(1, 1'b0, 4'h0, 1'b0, 4'h0);
      run_slots(12);
      n_checks++;
      if (busy !== 4'b0000) begin
         n_errors++;
         $display("FAIL busy_after_restart got=%b required=0000", busy);
      end
      n_checks++;
      if (rd_log.size() == 0 || rd_log[rd_log.size()-1] !== 18'h00300) begin
         n_errors++;
         $display("FAIL restart_addr got=%h required=00300",
                  rd_log.size() == 0 ? 18'h0 : rd_log[rd_log.size()-1]);
      end
   endtask

   task automatic test_overrun();
      n_checks++;
      if (overrun !== 1'b0) begin
         n_errors++;
         $display("FAIL overrun_early got=%b required=0", overrun);
      end
      pulse_start(3, 18'h00400, 18'h0040F, 4'h9);
      for (int s = 0; s < 3; s++) push_smp(s, 1'b0, 4'h0, 1'b0, 4'h0);
      run_slots(3);
      push_smp(3, 1'b1, 4'h5, 1'b1, 4'h9);
      rom_stall  = 1'b1;
      cen_period = 16;
      cen_left   = 3;
      wait_cen_left(2);
      repeat (40) @(negedge clk);
      rom_stall = 1'b0;
      wait_cen_left(0);
      repeat (30) @(negedge clk);
      cen_period = 8;
      n_checks++;
      if (overrun !== 1'b1) begin
         n_errors++;
         $display("FAIL overrun_flag got=%b required=1", overrun);
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL overrun_slot_count got=%0d outstanding required=0", exp_q.size());
      end
      exp_q.delete();
      push_smp(0, 1'b0, 4'h0, 1'b0, 4'h0);
      run_slots(1);
   endtask

   task automatic test_reset_fetch();
      int i;
      push_smp(1, 1'b0, 4'h0, 1'b0, 4'h0);
      push_smp(2, 1'b0, 4'h0, 1'b0, 4'h0);
      push_smp(3, 1'b1, 4'hA, 1'b0, 4'h9);
      run_slots(3);
      for (int s = 0; s < 3; s++) push_smp(s, 1'b0, 4'h0, 1'b0, 4'h0);
      run_slots(3);
      rom_stall = 1'b1;
      cen_left  = 1;
      i = 0;
      while (!rom_cs && i < 100) begin
         @(negedge clk);
         i++;
      end
      n_checks++;
      if (rom_cs !== 1'b1) begin
         n_errors++;
         $display("FAIL fetch_start got=%b required=1", rom_cs);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (rom_cs !== 1'b0 || busy !== 4'b0000) begin
         n_errors++;
         $display("FAIL reset_in_fetch got cs=%b busy=%b required cs=0 busy=0000", rom_cs, busy);
      end
      n_checks++;
      if (overrun !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_overrun got=%b required=0", overrun);
      end
      @(negedge clk);
      cen_left  = 0;
      rst_n     = 1'b1;
      rom_stall = 1'b0;
      @(negedge clk);
      exp_round(0, 1'b0, 4'h0, 1'b0, 4'h0);
      run_slots(4);
   endtask

   initial begin
      test_reset();
      test_phrase();
      test_same_clk();
      test_stop_restart();
      test_overrun();
      test_reset_fetch();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
